// File: rtl/accelerator_dnc_pkg.sv
// ============================================================================
// accelerator_dnc_pkg : shared constants and state encoding for DNC stages
// Rev 1.0
// ============================================================================
`default_nettype none

package accelerator_dnc_pkg;

  localparam int DNC_DATA_SIZE    = 64;
  localparam int DNC_CONTROL_SIZE = 64;
  localparam int DNC_SIZE_MAX     = 16;

  typedef logic [1:0] dnc_state_t;

  localparam logic [1:0] STARTER_STATE = 2'd0;
  localparam logic [1:0] LOAD_STATE    = 2'd1;
  localparam logic [1:0] EMIT_STATE    = 2'd2;
  localparam logic [1:0] END_STATE     = 2'd3;

  localparam logic [DNC_DATA_SIZE-1:0]    ZERO_DATA    = '0;
  localparam logic [DNC_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
  localparam logic [DNC_CONTROL_SIZE-1:0] ONE_CONTROL  = {{(DNC_CONTROL_SIZE-1){1'b0}}, 1'b1};

  // A depth of one still needs a one-bit address.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/accelerator_unsort_buffer.sv
// ============================================================================
// accelerator_unsort_buffer : register file with per-entry valid bits
// Rev 1.0
// ============================================================================
`default_nettype none

module accelerator_unsort_buffer
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE = DNC_DATA_SIZE,
  parameter int SIZE_MAX  = DNC_SIZE_MAX,
  parameter int IDX_W     = idx_width(SIZE_MAX)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid
);

  logic [DATA_SIZE-1:0] mem_q [SIZE_MAX];
  logic [DATA_SIZE-1:0] mem_d [SIZE_MAX];
  logic [SIZE_MAX-1:0]  valid_q;
  logic [SIZE_MAX-1:0]  valid_d;

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = '0;
    end else if (wr_en) begin
      mem_d[wr_addr]   = wr_data;
      valid_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SIZE_MAX; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign rd_valid = valid_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/accelerator_unsort_vector.sv
// ============================================================================
// accelerator_unsort_vector : scatter a sorted stream back to index order
// Rev 1.0
// ============================================================================
`default_nettype none

module accelerator_unsort_vector
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE    = DNC_DATA_SIZE,
  parameter int CONTROL_SIZE = DNC_CONTROL_SIZE,
  parameter int SIZE_MAX     = DNC_SIZE_MAX
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic                 PHI_IN_ENABLE,
  input  logic                 A_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] PHI_IN,
  input  logic [DATA_SIZE-1:0] A_IN,
  output logic                 W_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] W_OUT,
  output logic                 ERROR
);

  localparam int                       IDX_W      = idx_width(SIZE_MAX);
  localparam logic [DATA_SIZE-1:0]     SIZE_MAX_D = DATA_SIZE'(SIZE_MAX);
  localparam logic [DATA_SIZE-1:0]     ZERO_D     = DATA_SIZE'(ZERO_DATA);
  localparam logic [CONTROL_SIZE-1:0]  ZERO_C     = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0]  ONE_C      = CONTROL_SIZE'(ONE_CONTROL);

  dnc_state_t              state_q, state_d;
  logic [DATA_SIZE-1:0]    n_q, n_d;
  logic [CONTROL_SIZE-1:0] load_cnt_q, load_cnt_d;
  logic [CONTROL_SIZE-1:0] emit_cnt_q, emit_cnt_d;
  logic                    ready_q, ready_d;
  logic                    w_out_enable_q, w_out_enable_d;
  logic [DATA_SIZE-1:0]    w_out_q, w_out_d;
  logic                    error_q, error_d;

  logic                    buf_clr;
  logic                    buf_we;
  logic [DATA_SIZE-1:0]    buf_rd_data;
  logic                    buf_rd_valid;
  logic                    accept;
  logic                    in_range;
  logic [CONTROL_SIZE-1:0] last_idx;

  assign accept   = PHI_IN_ENABLE & A_IN_ENABLE;
  assign in_range = (PHI_IN < n_q);
  // Only meaningful in LOAD/EMIT, where n_q is at least one.
  assign last_idx = CONTROL_SIZE'(n_q) - ONE_C;

  accelerator_unsort_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_MAX  (SIZE_MAX),
    .IDX_W     (IDX_W)
  ) u_buffer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (buf_clr),
    .wr_en    (buf_we),
    .wr_addr  (PHI_IN[IDX_W-1:0]),
    .wr_data  (A_IN),
    .rd_addr  (emit_cnt_q[IDX_W-1:0]),
    .rd_data  (buf_rd_data),
    .rd_valid (buf_rd_valid)
  );

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    load_cnt_d     = load_cnt_q;
    emit_cnt_d     = emit_cnt_q;
    ready_d        = 1'b0;
    w_out_enable_d = 1'b0;
    w_out_d        = w_out_q;
    error_d        = error_q;
    buf_clr        = 1'b0;
    buf_we         = 1'b0;

    case (state_q)
      STARTER_STATE: begin
        if (START) begin
          n_d        = SIZE_N_IN;
          buf_clr    = 1'b1;
          error_d    = 1'b0;
          load_cnt_d = ZERO_C;
          emit_cnt_d = ZERO_C;
          if (SIZE_N_IN == ZERO_D) begin
            state_d = END_STATE;
          end else if (SIZE_N_IN > SIZE_MAX_D) begin
            error_d = 1'b1;
            state_d = END_STATE;
          end else begin
            state_d = LOAD_STATE;
          end
        end
      end
      LOAD_STATE: begin
        if (accept) begin
          // Out-of-range elements still count towards N so the stream stays aligned.
          if (in_range) begin
            buf_we = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          load_cnt_d = load_cnt_q + ONE_C;
          if (load_cnt_q == last_idx) begin
            emit_cnt_d = ZERO_C;
            state_d    = EMIT_STATE;
          end
        end
      end
      EMIT_STATE: begin
        w_out_enable_d = 1'b1;
        w_out_d        = buf_rd_valid ? buf_rd_data : ZERO_D;
        emit_cnt_d     = emit_cnt_q + ONE_C;
        if (emit_cnt_q == last_idx) begin
          state_d = END_STATE;
        end
      end
      END_STATE: begin
        ready_d = 1'b1;
        state_d = STARTER_STATE;
      end
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= STARTER_STATE;
      n_q            <= ZERO_D;
      load_cnt_q     <= ZERO_C;
      emit_cnt_q     <= ZERO_C;
      ready_q        <= 1'b0;
      w_out_enable_q <= 1'b0;
      w_out_q        <= ZERO_D;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      load_cnt_q     <= load_cnt_d;
      emit_cnt_q     <= emit_cnt_d;
      ready_q        <= ready_d;
      w_out_enable_q <= w_out_enable_d;
      w_out_q        <= w_out_d;
      error_q        <= error_d;
    end
  end

  assign READY        = ready_q;
  assign W_OUT_ENABLE = w_out_enable_q;
  assign W_OUT        = w_out_q;
  assign ERROR        = error_q;

endmodule

`default_nettype wire

// File: doc/accelerator_unsort_vector.md
# accelerator_unsort_vector

Inverse-permutation (scatter) stage for the DNC memory allocation path. It consumes a vector streamed in sorted order together with its permutation indices phi(t;j), and re-emits it in original index order: w(t;phi(t;j)) = a(t;j). It sits downstream of the sort stage and closes the loop back to index-ordered memory vectors.

## Interface
- DATA_SIZE, 64, data and index word width
- CONTROL_SIZE, 64, control word width (counters)
- SIZE_MAX, 16, buffer depth; largest supported N
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-high
- START  input  1  begin operation; sampled only in STARTER
- READY  output  1  one-cycle pulse at end of operation
- SIZE_N_IN  input  DATA_SIZE  vector length N, sampled with START
- PHI_IN_ENABLE  input  1  PHI_IN valid
- A_IN_ENABLE  input  1  A_IN valid
- PHI_IN  input  DATA_SIZE  destination index of current element
- A_IN  input  DATA_SIZE  element value, sorted order
- W_OUT_ENABLE  output  1  W_OUT valid
- W_OUT  output  DATA_SIZE  element value, original index order
- ERROR  output  1  sticky per operation: index out of range or N > SIZE_MAX

## Operation
- States: STARTER, LOAD, EMIT, END.
- STARTER: READY=0. On START=1: latch N, clear all buffer valid bits, clear ERROR, load/emit counters to 0.
  - N=0: go END.
  - N>SIZE_MAX: ERROR=1, go END.
  - else go LOAD.
- LOAD: element accepted on a cycle with PHI_IN_ENABLE=1 and A_IN_ENABLE=1. Only one enable high: ignored, not accepted.
  - PHI_IN < N: buf[PHI_IN] <= A_IN, valid[PHI_IN] <= 1. Duplicate index: later write wins.
  - PHI_IN >= N (full DATA_SIZE compare): write dropped, ERROR <= 1, element still counts.
  - After N accepted elements go EMIT.
- EMIT: for k = 0..N-1, one element per cycle: W_OUT_ENABLE=1, W_OUT = valid[k] ? buf[k] : ZERO_DATA. After k=N-1 go END.
- END: READY=1 for exactly one cycle, W_OUT_ENABLE=0, go STARTER.
- START outside STARTER ignored. Input enables outside LOAD ignored.
- Counters are CONTROL_SIZE wide; no wrap is possible since N <= SIZE_MAX.
- RST at any time: state STARTER, all outputs to reset values, valid bits cleared; in-flight operation discarded.
- Reset values: READY=0, W_OUT_ENABLE=0, W_OUT=ZERO_DATA, ERROR=0.

## Timing
- All outputs registered.
- Edge E0 samples START. For N>0, LOAD is active from the cycle after E0. An element presented in that cycle is accepted.
- Throughput: 1 element per cycle in both LOAD and EMIT.
- The edge that accepts the N-th element enters EMIT. The following N edges drive W_OUT_ENABLE=1 with indices 0..N-1. The edge after those asserts READY.
- Minimum START-to-READY latency for N>0 with back-to-back inputs: 2N+2 cycles.
- N=0 or N>SIZE_MAX: READY high in the cycle after E0+1, i.e. 2 edges after START. No W_OUT_ENABLE pulses.
- ERROR is valid from the edge of the offending accept. It holds until the next accepted START or RST.
- A new START is accepted the cycle after READY.

## Structure
- Shared package accelerator_dnc_pkg holds:
  - state encoding (STARTER/LOAD/EMIT/END)
  - ZERO_DATA and ZERO/ONE_CONTROL constants
- Sub-module accelerator_unsort_buffer: SIZE_MAX x DATA_SIZE register file with per-entry valid bits. It has one write port, one read port, and a synchronous clear-all.
- Top level holds the FSM, counters and range check.

## Test plan
- N=4; phi=(2,0,3,1), a=(10,11,12,13) back-to-back -> W_OUT 11,13,10,12 on 4 consecutive cycles; READY 1 cycle later; ERROR=0; latency 10 cycles.
- N=3; phi=(1,1,0), a=(5,6,7) -> W_OUT 7,6,0 (index 2 unwritten gives zero; duplicate index, last write wins); ERROR=0.
- N=2; phi=(0,5), a=(8,9) -> W_OUT 8,0; ERROR=1 until next START.
- N=0 -> READY 2 cycles after START, no W_OUT_ENABLE. N=SIZE_MAX+1 -> same timing, ERROR=1.
- Gapped input: enables low or only one high on alternate cycles, N=4 -> same output as back-to-back, nothing accepted on gap cycles.
- RST mid-LOAD after 2 of 4 elements -> all outputs reset next; a new START with N=1, phi=0, a=42 -> W_OUT 42, stale data not visible.
